// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined RISC-V core: word-addressed RAM plus a
// small MMIO block (64-bit timer with compare interrupt, scratch, halt/tohost).
module dmem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        err_o
);

    localparam logic [3:0] OFF_MTIME_LO    = 4'd0;
    localparam logic [3:0] OFF_MTIME_HI    = 4'd1;
    localparam logic [3:0] OFF_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] OFF_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] OFF_HALT        = 4'd4;
    localparam logic [3:0] OFF_SCRATCH     = 4'd5;

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [63:0]           mtime_next;
    logic [63:0]           mtimecmp_next;
    logic [31:0]           scratch;
    logic [31:0]           hi_shadow;
    logic                  is_ram;
    logic                  is_mmio;
    logic                  rd;
    logic                  wr_ram;
    logic                  wr_mmio;
    logic                  bad_access;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [3:0]            mmio_off;

    assign is_ram     = (data_addr_i[31:ADDR_WIDTH+2] == '0);
    assign is_mmio    = (data_addr_i[31:6] == MMIO_BASE[31:6]);
    assign ram_idx    = data_addr_i[ADDR_WIDTH+1:2];
    assign mmio_off   = data_addr_i[5:2];
    assign rd         = data_ce_i && !data_we_i;
    assign wr_ram     = data_ce_i && data_we_i && is_ram;
    assign wr_mmio    = data_ce_i && data_we_i && is_mmio;
    assign bad_access = data_ce_i && ((data_addr_i[1:0] != 2'b00) || !(is_ram || is_mmio));

    always_comb begin
        data_o = '0;
        if (rd) begin
            if (is_ram) begin
                data_o = mem[ram_idx];
            end else if (is_mmio) begin
                case (mmio_off)
                    OFF_MTIME_LO:    data_o = mtime[31:0];
                    OFF_MTIME_HI:    data_o = hi_shadow;
                    OFF_MTIMECMP_LO: data_o = mtimecmp[31:0];
                    OFF_MTIMECMP_HI: data_o = mtimecmp[63:32];
                    OFF_HALT:        data_o = {31'b0, halt_o};
                    OFF_SCRATCH:     data_o = scratch;
                    default:         data_o = '0;
                endcase
            end
        end
    end

    // A write to either mtime half replaces the increment for that cycle; halt freezes the timer entirely.
    always_comb begin
        mtime_next    = mtime;
        mtimecmp_next = mtimecmp;
        if (!halt_o) begin
            if (wr_mmio && mmio_off == OFF_MTIME_LO) begin
                mtime_next = {mtime[63:32], data_i};
            end else if (wr_mmio && mmio_off == OFF_MTIME_HI) begin
                mtime_next = {data_i, mtime[31:0]};
            end else begin
                mtime_next = mtime + 64'd1;
            end
        end
        if (wr_mmio && mmio_off == OFF_MTIMECMP_LO) begin
            mtimecmp_next = {mtimecmp[63:32], data_i};
        end else if (wr_mmio && mmio_off == OFF_MTIMECMP_HI) begin
            mtimecmp_next = {data_i, mtimecmp[31:0]};
        end
    end

    // RAM has no reset so program data survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            scratch     <= '0;
            hi_shadow   <= '0;
            timer_irq_o <= 1'b0;
            halt_o      <= 1'b0;
            halt_code_o <= '0;
            err_o       <= 1'b0;
        end else begin
            mtime       <= mtime_next;
            mtimecmp    <= mtimecmp_next;
            timer_irq_o <= (mtime_next >= mtimecmp_next);
            if (rd && is_mmio && mmio_off == OFF_MTIME_LO) begin
                hi_shadow <= mtime[63:32];
            end
            if (wr_mmio && mmio_off == OFF_SCRATCH) begin
                scratch <= data_i;
            end
            if (wr_mmio && mmio_off == OFF_HALT && !halt_o) begin
                halt_o      <= 1'b1;
                halt_code_o <= data_i;
            end
            if (bad_access) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core: the far end of the core's data_ce/data_we/data_addr/data_o/data_i interface.
- Provides a word-addressed RAM and a small MMIO block:
  - 64-bit cycle timer with compare interrupt
  - scratch register
  - halt/tohost register that the testbench uses to end simulation
- Sits beside the core in the SoC/bench top, with one instance per core.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (RAM = 4 KiB by default).
- MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window (64 B, 16 words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_ce_i  input  1  access enable from the core.
- data_we_i  input  1  1 = write, 0 = read; ignored when data_ce_i=0.
- data_addr_i  input  32  byte address.
- data_i  input  32  write data from the core.
- data_o  output  32  read data to the core (combinational).
- timer_irq_o  output  1  registered, mtime >= mtimecmp.
- halt_o  output  1  sticky; set by a write to HALT.
- halt_code_o  output  32  data of the first HALT write.
- err_o  output  1  sticky access-error flag.

Behaviour:
- Reset values (rst=0, asynchronous):
  - data_o: follows the decode rule below.
  - timer_irq_o=0, halt_o=0, halt_code_o=0, err_o=0.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, scratch=0, hi_shadow=0.
  - RAM array is not reset; its contents survive a reset asserted mid-run.
- Decode (word index = data_addr_i[31:2]):
  - RAM: data_addr_i[31:ADDR_WIDTH+2]==0; index = data_addr_i[ADDR_WIDTH+1:2].
  - MMIO: data_addr_i[31:6]==MMIO_BASE[31:6]; offset = data_addr_i[5:2].
  - Anything else is unmapped.
- Read path, zero latency:
  - data_o is combinational from address/state when data_ce_i=1 and data_we_i=0; otherwise 0.
  - The core samples data_o in the same cycle as the request.
- Write path: committed at the rising edge when data_ce_i=1 and data_we_i=1. A read in the next cycle returns the new value.
- data_addr_i[1:0]!=0 with data_ce_i=1:
  - The access still proceeds on the word index (low bits ignored).
  - err_o is set.
- Unmapped access: reads return 0, writes are dropped, err_o is set. err_o clears only on reset.
- MMIO map (offset : register):
  - 0 MTIME_LO (rw). Reading it copies mtime[63:32] into hi_shadow at the clock edge.
  - 1 MTIME_HI (rw). Reads return hi_shadow (torn-read-free 64-bit read: LO then HI).
  - 2 MTIMECMP_LO (rw); 3 MTIMECMP_HI (rw).
  - 4 HALT (w; reads return {31'b0, halt_o}).
  - 5 SCRATCH (rw).
  - 6..15: reserved; read 0, writes dropped, no error.
- Timer:
  - mtime increments by 1 each cycle (64-bit, carry from LO into HI, wraps all-ones to 0) while halt_o=0.
  - A write to MTIME_LO or MTIME_HI loads that half with data_i; there is no increment in that cycle, so the other half holds.
  - Frozen while halt_o=1.
  - timer_irq_o is registered from (mtime_next >= mtimecmp_next), so it reflects same-edge writes one cycle later. The compare is unsigned 64-bit.
- HALT:
  - The first write sets halt_o=1 and halt_code_o=data_i.
  - Later HALT writes are ignored.
  - RAM, SCRATCH and MTIMECMP stay writable after halt.
- Only one access is possible per cycle, so simultaneous events reduce to a write versus the timer increment. The write wins, as stated above.

Test Plan:
- Reset then write 32'hDEAD_BEEF to 0x0000_0010; read the same address next cycle -> data_o=32'hDEAD_BEEF in the same cycle as the read; err_o=0.
- Write 0x11 to 0x0000_0004; pulse rst low mid-run; read 0x0000_0004 -> 0x11 (RAM kept); timer_irq_o=0, err_o=0, halt_o=0.
- Read 0x0000_0006 (misaligned) -> returns word 1 data and err_o=1. Read 0x2000_0000 -> data_o=0 and err_o stays 1. Write to 0x0000_1000 (beyond a 4 KiB RAM) -> dropped.
- Write MTIME_LO=32'hFFFF_FFFE and MTIME_HI=0; after 3 cycles read LO then HI -> LO=32'h0000_0001 and HI=1 (carry, read from shadow).
- Write MTIMECMP_HI=0 and MTIMECMP_LO=100 with mtime near 0 -> timer_irq_o rises on the first cycle after mtime reaches 100 and stays 1. Rewrite MTIMECMP_HI=1 -> timer_irq_o drops one cycle later.
- Write HALT=32'h1, then HALT=32'h5 -> halt_o=1, halt_code_o=1. mtime reads constant over 10 cycles. SCRATCH write/readback still works.
